dmem_scratch_router: RTL and testbench

//  Data-side memory router directly downstream of the scalar core's data port.

---
 rtl/dmem_scratch_router.sv | 172 +++++++++++++++++
 tb/tb_dmem_scratch_router.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_scratch_router.sv
// Data-side router: steers the core's single outstanding load/store to a local
// word-addressed scratchpad or to the external data bus, returns a one-cycle
// ready pulse with load data, and aborts external accesses that never complete.
//
// Handshakes: the core raises core_req_i and holds it and all fields stable
// until it sees the single-cycle core_ready_o pulse; a request is taken only
// in IDLE. On the external side ext_req_o stays high with stable
// ext_write_o/ext_addr_o/ext_wdata_o until ext_ready_i is seen (or the timeout
// fires), and ext_req_o drops on the following edge.
module dmem_scratch_router #(
  parameter int DWidth     = 32,
  parameter int SpDepth    = 256,
  parameter int SpLatency  = 1,
  parameter int TimeoutCyc = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_write_i,
  input  logic              core_scratch_i,
  input  logic [DWidth-1:0] core_addr_i,
  input  logic [DWidth-1:0] core_wdata_i,
  output logic              core_ready_o,
  output logic [DWidth-1:0] core_rdata_o,
  output logic              ext_req_o,
  output logic              ext_write_o,
  output logic [DWidth-1:0] ext_addr_o,
  output logic [DWidth-1:0] ext_wdata_o,
  input  logic              ext_ready_i,
  input  logic [DWidth-1:0] ext_rdata_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int IdxW   = $clog2(SpDepth);
  localparam int CntMax = (TimeoutCyc > SpLatency) ? TimeoutCyc : SpLatency;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam logic [DWidth-1:0] TimeoutData = DWidth'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SP_ACC   = 2'd1,
    EXT_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CntW-1:0]     cnt;
  logic                cap_write;
  logic [IdxW-1:0]     cap_idx;
  logic [DWidth-1:0]   cap_wdata;
  logic [DWidth-1:0]   rdata_q;
  logic                ext_req_q;
  logic                ext_write_q;
  logic [DWidth-1:0]   ext_addr_q;
  logic [DWidth-1:0]   ext_wdata_q;
  logic                err_q;
  logic [DWidth-1:0]   sp_mem [SpDepth];

  logic accept;
  logic sp_last;
  logic ext_timeout;
  logic sp_wr_en;

  assign accept      = (state == IDLE) && core_req_i;
  assign sp_last     = (cnt == CntW'(SpLatency - 1));
  // Fires on the last permitted EXT_WAIT cycle; a ready in that same cycle wins.
  assign ext_timeout = (cnt == CntW'(TimeoutCyc - 1));
  // Reset at the write edge suppresses the store.
  assign sp_wr_en    = !rst_i && (state == SP_ACC) && sp_last && cap_write;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (core_req_i) state_nxt = core_scratch_i ? SP_ACC : EXT_WAIT;
      SP_ACC:   if (sp_last) state_nxt = DONE;
      EXT_WAIT: if (ext_ready_i || ext_timeout) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Cycle counter for scratchpad latency and external timeout; restarts on every state change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if ((state == SP_ACC) || (state == EXT_WAIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Capture the accepted request so the core's fields are not needed afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_write <= core_write_i;
      cap_idx   <= core_addr_i[2 +: IdxW];
      cap_wdata <= core_wdata_i;
    end
  end

  // Registered external bus outputs; address/data only change when a new external access starts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ext_req_q   <= 1'b0;
      ext_write_q <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
    end else begin
      ext_req_q <= (state_nxt == EXT_WAIT);
      if (accept && !core_scratch_i) begin
        ext_write_q <= core_write_i;
        ext_addr_q  <= core_addr_i;
        ext_wdata_q <= core_wdata_i;
      end else if (state_nxt != EXT_WAIT) begin
        ext_write_q <= 1'b0;
      end
    end
  end

  // Load data register: scratchpad read, external read data, or the timeout marker.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if ((state == SP_ACC) && sp_last && !cap_write) begin
      rdata_q <= sp_mem[cap_idx];
    end else if (state == EXT_WAIT) begin
      if (ext_ready_i) begin
        if (!cap_write) rdata_q <= ext_rdata_i;
      end else if (ext_timeout) begin
        rdata_q <= TimeoutData;
      end
    end
  end

  // Sticky bus-timeout flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if ((state == EXT_WAIT) && !ext_ready_i && ext_timeout) begin
      err_q <= 1'b1;
    end
  end

  // Scratchpad array; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (sp_wr_en) sp_mem[cap_idx] <= cap_wdata;
  end

  assign core_ready_o = (state == DONE);
  assign core_rdata_o = rdata_q;
  assign busy_o       = (state != IDLE);
  assign err_o        = err_q;
  assign ext_req_o    = ext_req_q;
  assign ext_write_o  = ext_write_q;
  assign ext_addr_o   = ext_addr_q;
  assign ext_wdata_o  = ext_wdata_q;

endmodule

// File: tb/tb_dmem_scratch_router.sv
// Bench for dmem_scratch_router: directed scenarios followed by a randomized
// mix of scratchpad and external accesses, checked against a word-array model.
module tb_dmem_scratch_router;

  localparam int SP_LAT = 1;
  localparam int TO     = 15;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        core_req = 1'b0, core_write = 1'b0, core_scratch = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic        core_ready;
  logic [31:0] core_rdata;
  logic        ext_req, ext_write;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_ready = 1'b0;
  logic [31:0] ext_rdata = '0;
  logic        busy, err;

  dmem_scratch_router #(
    .DWidth(32), .SpDepth(256), .SpLatency(SP_LAT), .TimeoutCyc(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_write_i(core_write), .core_scratch_i(core_scratch),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_ready_o(core_ready), .core_rdata_o(core_rdata),
    .ext_req_o(ext_req), .ext_write_o(ext_write),
    .ext_addr_o(ext_addr), .ext_wdata_o(ext_wdata),
    .ext_ready_i(ext_ready), .ext_rdata_i(ext_rdata),
    .busy_o(busy), .err_o(err)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] sp_mem [256];
  bit          sp_valid [256];
  logic [31:0] exp_q[$];
  logic [31:0] rdata_model = '0;
  bit          rdata_known = 1'b1;
  bit          err_model = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; all driving and sampling happens 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    err_model   = 1'b0;
    rdata_model = '0;
    rdata_known = 1'b1;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic sp_op(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    logic [7:0] idx;
    int  cyc;
    bit  got;
    bit  bus_quiet;
    idx = addr[9:2];
    cyc = 0; got = 1'b0; bus_quiet = 1'b1;
    check("sp_idle_before", busy, 1'b0);
    core_req = 1'b1; core_write = wr; core_scratch = 1'b1;
    core_addr = addr; core_wdata = wd;
    if (!wr) exp_q.push_back(sp_mem[idx]);
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ext_req) bus_quiet = 1'b0;
      if (core_ready) begin got = 1'b1; cyc = i; break; end
    end
    check("sp_ready_seen", got, 1'b1);
    check("sp_latency", cyc, SP_LAT + 1);
    check("sp_bus_quiet", bus_quiet, 1'b1);
    if (wr) begin
      sp_mem[idx] = wd; sp_valid[idx] = 1'b1;
    end else begin
      rdata_model = exp_q.pop_front(); rdata_known = 1'b1;
    end
    if (rdata_known) check("sp_rdata", core_rdata, rdata_model);
    check("sp_err", err, err_model);
    core_req = 1'b0;
    step();
    check("sp_ready_one_cycle", core_ready, 1'b0);
    check("sp_idle_after", busy, 1'b0);
  endtask

  // lat = EXT_WAIT cycle (1-based) in which ext_ready is raised; 0 = never.
  task automatic ext_op(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input logic [31:0] rd);
    int  cyc;
    int  req_cnt;
    int  exp_lat;
    bit  got;
    bit  bus_ok;
    cyc = 0; req_cnt = 0; got = 1'b0; bus_ok = 1'b1;
    exp_lat = (lat == 0) ? TO : lat;
    check("ext_idle_before", busy, 1'b0);
    core_req = 1'b1; core_write = wr; core_scratch = 1'b0;
    core_addr = addr; core_wdata = wd;
    if (!wr) exp_q.push_back((lat == 0) ? DEAD : rd);
    for (int i = 1; i <= 40; i++) begin
      step();
      if (core_ready) begin got = 1'b1; cyc = i; ext_ready = 1'b0; break; end
      if (ext_req) begin
        req_cnt++;
        if (ext_addr !== addr || ext_write !== wr || (wr && ext_wdata !== wd)) bus_ok = 1'b0;
      end
      if (i == lat) begin ext_ready = 1'b1; ext_rdata = rd; end
      else begin ext_ready = 1'b0; ext_rdata = $urandom(); end
    end
    check("ext_ready_seen", got, 1'b1);
    check("ext_req_cycles", req_cnt, exp_lat);
    check("ext_done_latency", cyc, exp_lat + 1);
    check("ext_bus_stable", bus_ok, 1'b1);
    check("ext_req_dropped", ext_req, 1'b0);
    if (lat == 0) err_model = 1'b1;
    if (!wr) begin
      rdata_model = exp_q.pop_front(); rdata_known = 1'b1;
    end else if (lat == 0) begin
      rdata_known = 1'b0;
    end
    if (rdata_known) check("ext_rdata", core_rdata, rdata_model);
    check("ext_err", err, err_model);
    core_req = 1'b0;
    step();
    check("ext_ready_one_cycle", core_ready, 1'b0);
    check("ext_idle_after", busy, 1'b0);
  endtask

  function automatic logic [31:0] sp_addr(input int idx);
    logic [31:0] a;
    a = $urandom();
    a[9:2] = 8'(idx);
    return a;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int r1, r2;
    bit got;
    logic [31:0] w;
    for (int i = 0; i < 256; i++) sp_valid[i] = 1'b0;

    // Reset held for two edges.
    rst = 1'b1;
    step(); step();
    check("rst_core_ready", core_ready, 1'b0);
    check("rst_ext_req", ext_req, 1'b0);
    check("rst_ext_write", ext_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_core_rdata", core_rdata, 32'h0);
    check("rst_ext_addr", ext_addr, 32'h0);
    check("rst_ext_wdata", ext_wdata, 32'h0);
    rst = 1'b0;
    model_reset();
    step();

    // Scratchpad store/load and aliasing.
    sp_op(1'b1, 32'h0000_0040, 32'h1234_5678);
    sp_op(1'b0, 32'h0000_0040, 32'h0);
    check("sp_load_value", rdata_model, 32'h1234_5678);
    sp_op(1'b0, 32'h0000_0440, 32'h0);
    sp_op(1'b1, 32'h0000_0000, 32'hA5A5_0001);
    sp_op(1'b1, 32'h0000_03FC, 32'h5A5A_00FF);
    sp_op(1'b0, 32'hFFFF_FFFF, 32'h0);
    sp_op(1'b0, 32'h0000_0400, 32'h0);

    // External load, ready after 5 cycles.
    ext_op(1'b0, 32'h8000_0000, 32'h0, 5, 32'hCAFE_F00D);
    // Store completion leaves read data untouched.
    ext_op(1'b1, 32'h8000_0010, 32'h0BAD_CAFE, 3, 32'h1111_1111);
    // Ready honoured in the first and in the last permitted cycle.
    ext_op(1'b0, 32'h8000_0020, 32'h0, 1, 32'h0000_0001);
    ext_op(1'b0, 32'h8000_0024, 32'h0, TO, 32'h7777_8888);
    check("no_err_before_timeout", err, 1'b0);

    // External store that never completes.
    ext_op(1'b1, 32'h9000_0000, 32'hFEED_0000, 0, 32'h0);
    sp_op(1'b0, 32'h0000_0040, 32'h0);
    ext_op(1'b0, 32'h9000_0004, 32'h0, 0, 32'h0);
    check("err_sticky", err, 1'b1);

    // Request held high across DONE: re-accepted only after an IDLE cycle.
    core_req = 1'b1; core_write = 1'b0; core_scratch = 1'b1; core_addr = 32'h0000_0040;
    r1 = 0; r2 = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (r1 != 0 && i == r1 + 1) check("held_idle_gap", busy, 1'b0);
      if (core_ready) begin
        if (r1 == 0) r1 = i;
        else begin r2 = i; break; end
      end
    end
    check("held_first_ready", r1, SP_LAT + 1);
    check("held_second_ready", r2, 2 * SP_LAT + 3);
    check("held_rdata", core_rdata, sp_mem[8'h10]);
    rdata_model = sp_mem[8'h10]; rdata_known = 1'b1;
    core_req = 1'b0;
    step();
    check("held_idle_after", busy, 1'b0);

    // Spurious ext_ready while idle.
    ext_ready = 1'b1; ext_rdata = 32'h5555_AAAA;
    step();
    ext_ready = 1'b0;
    check("spur_busy", busy, 1'b0);
    check("spur_ext_req", ext_req, 1'b0);
    check("spur_core_ready", core_ready, 1'b0);
    check("spur_rdata", core_rdata, rdata_model);
    step();
    check("spur_core_ready2", core_ready, 1'b0);
    check("spur_busy2", busy, 1'b0);

    // Randomized mix.
    for (int n = 0; n < 40; n++) begin
      int kind, lat, idx;
      kind = $urandom_range(0, 3);
      lat  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
      case (kind)
        0: begin
          idx = $urandom_range(0, 255);
          sp_op(1'b1, sp_addr(idx), $urandom());
        end
        1: begin
          idx = $urandom_range(0, 255);
          if (!sp_valid[idx]) sp_op(1'b1, sp_addr(idx), $urandom());
          sp_op(1'b0, sp_addr(idx), 32'h0);
        end
        2: ext_op(1'b0, $urandom(), 32'h0, lat, $urandom());
        default: ext_op(1'b1, $urandom(), $urandom(), lat, $urandom());
      endcase
    end

    // Reset during EXT_WAIT.
    core_req = 1'b1; core_write = 1'b0; core_scratch = 1'b0; core_addr = 32'hA000_0000;
    step();
    check("mid_ext_req_up", ext_req, 1'b1);
    step();
    rst = 1'b1; core_req = 1'b0;
    step();
    check("mid_ext_req_drop", ext_req, 1'b0);
    check("mid_ext_busy", busy, 1'b0);
    check("mid_ext_ready", core_ready, 1'b0);
    check("mid_ext_err", err, 1'b0);
    rst = 1'b0;
    model_reset();
    step();

    // Reset during SP_ACC of a store: the write must not land.
    sp_op(1'b1, 32'h0000_0040, 32'h1234_5678);
    w = sp_mem[8'h10];
    core_req = 1'b1; core_write = 1'b1; core_scratch = 1'b1;
    core_addr = 32'h0000_0040; core_wdata = 32'hBAD0_BAD0;
    step();
    check("mid_sp_busy", busy, 1'b1);
    rst = 1'b1; core_req = 1'b0;
    step();
    check("mid_sp_busy_drop", busy, 1'b0);
    check("mid_sp_ready", core_ready, 1'b0);
    check("mid_sp_ext_req", ext_req, 1'b0);
    rst = 1'b0;
    model_reset();
    step();
    sp_op(1'b0, 32'h0000_0040, 32'h0);
    check("mid_sp_word_kept", core_rdata, w);
    got = 1'b1;
    ext_op(1'b0, 32'h8000_1000, 32'h0, 2, 32'h2468_ACE0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
